// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode pipeline stage.
//   - default bundle field widths and the bubble / halt encodings
//   - fd_bundle_t: one fetch->decode bundle at the default widths; the
//     field order matches the flat bus packing used inside the stage
//   - fd_state_e: stage run state
package fetch_decode_stage_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_REG_AW = 3;
    localparam int DEF_CNT_W  = 8;

    localparam logic [DEF_DATA_W-1:0] DEF_NOP_INSTR  = 10'b0100000000;
    localparam logic [DEF_DATA_W-1:0] DEF_HALT_INSTR = 10'b1111000000;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_DATA_W-1:0] jmp_addr;
        logic [DEF_DATA_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr_addr;
        logic [DEF_REG_AW-1:0] rs1;
        logic [DEF_REG_AW-1:0] rs2;
    } fd_bundle_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fd_state_e;

endpackage

// File: rtl/fd_bundle_reg.sv
// One bundle slot of the stage's skid buffer.
// Ports:
//   clk    - rising-edge clock
//   load   - capture d and mark the slot valid
//   clear  - empty the slot and zero its data (wins over load)
//   d      - flat bundle to capture
//   q      - held bundle
//   valid  - slot occupied
// Reset is applied by the parent through clear.
module fd_bundle_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch -> decode pipeline register with a two-entry skid buffer.
// MAIN drives the decode outputs, SKID catches a bundle accepted while MAIN
// is stalled, so in_ready can be a flop without losing data.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid / in_ready          - fetch handshake (in_ready registered)
//   in_instr .. in_instr_addr    - fetch bundle fields (DATA_W)
//   in_rs1, in_rs2               - read-register indices (REG_AW)
//   flush                        - squash both entries and any same-cycle input
//   halt_req                     - squash and park the stage in HALT
//   out_valid / out_ready        - decode handshake
//   out_instr .. out_instr_addr  - decode bundle fields (DATA_W)
//   out_rs1, out_rs2             - decode register indices (REG_AW)
//   bubble_cnt                   - saturating count of flush cycles
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 REG_AW     = DEF_REG_AW,
    parameter logic [DATA_W-1:0]  NOP_INSTR  = DATA_W'(DEF_NOP_INSTR),
    parameter logic [DATA_W-1:0]  HALT_INSTR = DATA_W'(DEF_HALT_INSTR),
    parameter int                 CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_jmp_addr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr_addr,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              flush,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_jmp_addr,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr_addr,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int BW = 5*DATA_W + 2*REG_AW;

    fd_state_e state_q, state_d;

    logic [BW-1:0] in_bus, main_d, main_q, skid_q;
    logic          main_vld, skid_vld;
    logic          main_ld, main_clr, skid_ld, skid_clr;
    logic          in_fire, out_fire, kill, skid_vld_next;
    logic [DATA_W-1:0] last_addr;

    logic [DATA_W-1:0] m_instr, m_imm, m_jmp_addr, m_pc, m_instr_addr;
    logic [REG_AW-1:0] m_rs1, m_rs2;

    // Same field order as fd_bundle_t.
    assign in_bus = {in_instr, in_imm, in_jmp_addr, in_pc, in_instr_addr, in_rs1, in_rs2};
    assign {m_instr, m_imm, m_jmp_addr, m_pc, m_instr_addr, m_rs1, m_rs2} = main_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_vld && out_ready;
    // In HALT both slots are already empty, so flush there is harmless.
    assign kill     = flush || (halt_req && state_q == ST_RUN);

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && halt_req) state_d = ST_HALT;
    end

    // ---------------- skid buffer control ----------------
    always_comb begin
        main_ld  = 1'b0;
        main_clr = 1'b0;
        main_d   = in_bus;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (rst || kill) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (out_fire || !main_vld) begin
            // MAIN is free this edge: oldest bundle (SKID) goes first.
            if (skid_vld) begin
                main_ld  = 1'b1;
                main_d   = skid_q;
                skid_clr = 1'b1;
            end else if (in_fire) begin
                main_ld  = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (in_fire) begin
            skid_ld = 1'b1;
        end
    end

    assign skid_vld_next = skid_ld || (skid_vld && !skid_clr);

    fd_bundle_reg #(.W(BW)) u_main (
        .clk   (clk),
        .load  (main_ld),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q),
        .valid (main_vld)
    );

    fd_bundle_reg #(.W(BW)) u_skid (
        .clk   (clk),
        .load  (skid_ld),
        .clear (skid_clr),
        .d     (in_bus),
        .q     (skid_q),
        .valid (skid_vld)
    );

    // ---------------- registered side state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            last_addr  <= '0;
            bubble_cnt <= '0;
        end else begin
            in_ready <= !skid_vld_next && (state_d == ST_RUN);
            // A bundle squashed in its arrival cycle never counts as accepted.
            if (in_fire && !kill)
                last_addr <= in_instr_addr;
            if (flush && bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // ---------------- output mux ----------------
    always_comb begin
        out_valid      = 1'b0;
        out_instr      = NOP_INSTR;
        out_imm        = '0;
        out_jmp_addr   = '0;
        out_pc         = '0;
        out_instr_addr = last_addr;
        out_rs1        = '0;
        out_rs2        = '0;
        if (state_q == ST_HALT) begin
            out_valid      = 1'b1;
            out_instr      = HALT_INSTR;
            out_instr_addr = '0;
        end else if (main_vld) begin
            out_valid      = 1'b1;
            out_instr      = m_instr;
            out_imm        = m_imm;
            out_jmp_addr   = m_jmp_addr;
            out_pc         = m_pc;
            out_instr_addr = m_instr_addr;
            out_rs1        = m_rs1;
            out_rs2        = m_rs2;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: the driver queues every accepted
// bundle, a monitor pops and compares on each output transfer. A second
// instance with a 2-bit counter exercises bubble_cnt saturation.
module tb_fetch_decode_stage;
    import fetch_decode_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst, in_valid, flush, halt_req, out_ready;
    logic [9:0] in_instr, in_imm, in_jmp_addr, in_pc, in_instr_addr;
    logic [2:0] in_rs1, in_rs2;

    logic       in_ready, out_valid;
    logic [9:0] out_instr, out_imm, out_jmp_addr, out_pc, out_instr_addr;
    logic [2:0] out_rs1, out_rs2;
    logic [7:0] bubble_cnt;

    logic       in_ready2, out_valid2;
    logic [9:0] out_instr2, out_imm2, out_jmp_addr2, out_pc2, out_instr_addr2;
    logic [2:0] out_rs12, out_rs22;
    logic [1:0] bubble_cnt2;

    int checks = 0, errors = 0;
    int mon_checks = 0, mon_errors = 0;
    bit mon_en = 1'b1;
    fd_bundle_t exp_q[$];

    always #5 clk = ~clk;

    fetch_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm(in_imm), .in_jmp_addr(in_jmp_addr),
        .in_pc(in_pc), .in_instr_addr(in_instr_addr), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .flush(flush), .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_imm(out_imm), .out_jmp_addr(out_jmp_addr),
        .out_pc(out_pc), .out_instr_addr(out_instr_addr), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .bubble_cnt(bubble_cnt)
    );

    fetch_decode_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_imm(in_imm), .in_jmp_addr(in_jmp_addr),
        .in_pc(in_pc), .in_instr_addr(in_instr_addr), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .flush(flush), .halt_req(halt_req), .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_imm(out_imm2), .out_jmp_addr(out_jmp_addr2),
        .out_pc(out_pc2), .out_instr_addr(out_instr_addr2), .out_rs1(out_rs12),
        .out_rs2(out_rs22), .bubble_cnt(bubble_cnt2)
    );

    // Directed bundle derived from one tag value (tags kept below 0x100).
    function automatic fd_bundle_t mk(input logic [9:0] v);
        fd_bundle_t b;
        b.instr      = v;
        b.imm        = v ^ 10'h155;
        b.jmp_addr   = v + 10'd3;
        b.pc         = v + 10'd1;
        b.instr_addr = v + 10'h200;
        b.rs1        = v[2:0];
        b.rs2        = v[5:3];
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input fd_bundle_t b);
        in_instr      = b.instr;
        in_imm        = b.imm;
        in_jmp_addr   = b.jmp_addr;
        in_pc         = b.pc;
        in_instr_addr = b.instr_addr;
        in_rs1        = b.rs1;
        in_rs2        = b.rs2;
    endtask

    // Present one bundle, wait (bounded) for in_ready, queue it as expected.
    task automatic send(input logic [9:0] v);
        int n = 0;
        drive(mk(v));
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_%0h: in_ready stayed 0 for %0d cycles", v, n);
        end else begin
            exp_q.push_back(mk(v));
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: an output transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            fd_bundle_t got, exp;
            got = '{out_instr, out_imm, out_jmp_addr, out_pc, out_instr_addr, out_rs1, out_rs2};
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL mon_unexpected: got %h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    mon_errors++;
                    $display("FAIL mon_bundle: got %h expected %h", got, exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; halt_req = 1'b0; out_ready = 1'b0;
        drive('0);

        // ---- reset ----
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'h100);
        chk("rst_bubble",    32'(bubble_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd0);
        chk("rst_instr_addr", 32'(out_instr_addr), 32'd0);
        rst = 1'b0;
        tick();
        chk("in_ready_rise", 32'(in_ready), 32'd1);

        // ---- streaming ----
        out_ready = 1'b1;
        send(10'h011);
        chk("stream_latency_valid", 32'(out_valid), 32'd1);
        chk("stream_latency_instr", 32'(out_instr), 32'h011);
        send(10'h022);
        send(10'h033);
        chk("stream_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_instr", 32'(out_instr), 32'h100);
        chk("idle_out_pc", 32'(out_pc), 32'd0);
        chk("idle_instr_addr_kept", 32'(out_instr_addr), 32'h233);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // ---- backpressure ----
        out_ready = 1'b0;
        send(10'h0A1);
        send(10'h0B2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("bp_hold_instr", 32'(out_instr), 32'h0A1);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);

        // ---- flush with both entries full ----
        out_ready = 1'b0;
        send(10'h0C3);
        send(10'h0D4);
        drive(mk(10'h0E5));
        in_valid = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_instr", 32'(out_instr), 32'h100);
        chk("flush_bubble", 32'(bubble_cnt), 32'd1);
        chk("flush_instr_addr_kept", 32'(out_instr_addr), 32'h2D4);
        tick();
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_no_ghost", 32'(out_valid), 32'd0);

        // ---- flush drops an input that would otherwise be accepted ----
        drive(mk(10'h0E5));
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("drop_out_valid", 32'(out_valid), 32'd0);
        chk("drop_bubble", 32'(bubble_cnt), 32'd2);
        chk("drop_instr_addr_kept", 32'(out_instr_addr), 32'h2D4);

        // ---- halt together with flush ----
        send(10'h0F6);
        mon_en = 1'b0;
        halt_req = 1'b1; flush = 1'b1;
        exp_q.delete();
        tick();
        halt_req = 1'b0; flush = 1'b0;
        chk("halt_bubble", 32'(bubble_cnt), 32'd3);
        for (int i = 0; i < 10; i++) begin
            out_ready = i[0];
            tick();
            chk("halt_out_valid", 32'(out_valid), 32'd1);
            chk("halt_out_instr", 32'(out_instr), 32'h3C0);
            chk("halt_in_ready", 32'(in_ready), 32'd0);
        end
        chk("halt_instr_addr", 32'(out_instr_addr), 32'd0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("halt_rst_valid", 32'(out_valid), 32'd0);
        chk("halt_rst_instr", 32'(out_instr), 32'h100);
        chk("halt_rst_bubble", 32'(bubble_cnt), 32'd0);
        tick();
        chk("halt_rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;
        out_ready = 1'b1;
        send(10'h017);
        tick();

        // ---- bubble counter saturation ----
        flush = 1'b1;
        repeat (5) tick();
        flush = 1'b0;
        chk("sat_cnt2", 32'(bubble_cnt2), 32'd3);
        chk("sat_cnt8", 32'(bubble_cnt), 32'd5);

        // ---- final drain (bounded) ----
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        tick();

        checks += mon_checks;
        errors += mon_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
